// File: rtl/pipe_tap_reg.sv
// pipe_tap_reg: multi-lane pipeline register with a run-time selectable output tap.
// Stages 1..DEPTH hold data plus a valid bit. tap_sel picks which stage feeds
// dout/out_valid (0 = bypass). count tracks how many valid entries are stored.
//
// Valid semantics: in_valid only tags din; it never stalls the pipe. When ce=1,
// data shifts whether or not it is valid, and empty slots carry vld=0.
// out_valid is the tag of whichever tap is selected. There is no ready/backpressure.
module pipe_tap_reg #(
  parameter int WIDTH = 18,
  parameter int LANES = 1,
  parameter int DEPTH = 2,
  parameter int TSW   = (DEPTH < 2) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ce,
  input  logic                   clr,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] din,
  input  logic [TSW-1:0]         tap_sel,
  output logic [LANES*WIDTH-1:0] dout,
  output logic                   out_valid,
  output logic [TSW-1:0]         count
);

  localparam int DW = LANES * WIDTH;

  if (DEPTH == 0) begin : g_bypass
    // No storage: a pure wire from input to output. Control inputs have no effect.
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, reset, ce, clr, tap_sel};
    assign dout        = din;
    assign out_valid   = in_valid;
    assign count       = '0;
  end else begin : g_pipe
    localparam logic [TSW-1:0] DEPTH_T = TSW'(DEPTH);

    logic [DW-1:0]  stage_q [1:DEPTH];
    logic [1:DEPTH] vld_q;
    logic [TSW-1:0] count_q;
    logic [TSW-1:0] tap_eff;

    // Stage registers with priority clr > ce > hold. count moves by the entry
    // entering minus the entry leaving, so it stays equal to popcount(vld_q).
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int i = 1; i <= DEPTH; i++) stage_q[i] <= '0;
        vld_q   <= '0;
        count_q <= '0;
      end else if (clr) begin
        for (int i = 1; i <= DEPTH; i++) stage_q[i] <= '0;
        vld_q   <= '0;
        count_q <= '0;
      end else if (ce) begin
        stage_q[1] <= din;
        vld_q[1]   <= in_valid;
        for (int i = 2; i <= DEPTH; i++) begin
          stage_q[i] <= stage_q[i-1];
          vld_q[i]   <= vld_q[i-1];
        end
        count_q <= count_q + TSW'(in_valid) - TSW'(vld_q[DEPTH]);
      end
    end

    // Output tap mux. Tap values above DEPTH clamp to the last stage, and tap 0 bypasses.
    always_comb begin
      tap_eff   = (tap_sel > DEPTH_T) ? DEPTH_T : tap_sel;
      dout      = din;
      out_valid = in_valid;
      for (int k = 1; k <= DEPTH; k++) begin
        if (tap_eff == TSW'(k)) begin
          dout      = stage_q[k];
          out_valid = vld_q[k];
        end
      end
    end

    assign count = count_q;
  end

endmodule

// File: tb/tb_pipe_tap_reg.sv
// tb_pipe_tap_reg: self-checking bench for pipe_tap_reg (LANES=3, DEPTH=4).
// A behavioural model of the stages produces the expected {dout, out_valid, count}.
// That expected value is queued when each cycle's stimulus is driven. It is popped and
// compared against the DUT outputs, which are sampled mid-cycle away from the clock edge.
module tb_pipe_tap_reg;

  localparam int WIDTH = 18;
  localparam int LANES = 3;
  localparam int DEPTH = 4;
  localparam int TSW   = 3;
  localparam int DW    = WIDTH * LANES;
  localparam int W     = DW + 1 + TSW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic           ce, clr, in_valid;
  logic [DW-1:0]  din;
  logic [TSW-1:0] tap_sel;
  logic [DW-1:0]  dout;
  logic           out_valid;
  logic [TSW-1:0] count;

  pipe_tap_reg #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .clr       (clr),
    .in_valid  (in_valid),
    .din       (din),
    .tap_sel   (tap_sel),
    .dout      (dout),
    .out_valid (out_valid),
    .count     (count)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  logic [DW-1:0] m_stage [1:DEPTH];
  logic          m_vld   [1:DEPTH];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_out();
    int t;
    int pop;
    logic [DW-1:0] d;
    logic v;
    pop = 0;
    for (int i = 1; i <= DEPTH; i++) pop += int'(m_vld[i]);
    t = (int'(tap_sel) > DEPTH) ? DEPTH : int'(tap_sel);
    if (t == 0) begin
      d = din;
      v = in_valid;
    end else begin
      d = m_stage[t];
      v = m_vld[t];
    end
    return {d, v, TSW'(pop)};
  endfunction

  task automatic model_clear();
    for (int i = 1; i <= DEPTH; i++) begin
      m_stage[i] = '0;
      m_vld[i]   = 1'b0;
    end
  endtask

  task automatic model_step();
    if (clr) begin
      model_clear();
    end else if (ce) begin
      for (int i = DEPTH; i >= 2; i--) begin
        m_stage[i] = m_stage[i-1];
        m_vld[i]   = m_vld[i-1];
      end
      m_stage[1] = din;
      m_vld[1]   = in_valid;
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic c, input logic cl, input logic iv,
                       input logic [DW-1:0] d, input logic [TSW-1:0] t, input string tag);
    logic [W-1:0] e;
    @(negedge clk);
    ce = c; clr = cl; in_valid = iv; din = d; tap_sel = t;
    exp_q.push_back(model_out());
    #1;
    e = exp_q.pop_front();
    check({tag, ".dout"},  64'(dout),      64'(e[W-1 -: DW]));
    check({tag, ".valid"}, 64'(out_valid), 64'(e[TSW]));
    check({tag, ".count"}, 64'(count),     64'(e[TSW-1:0]));
    @(posedge clk);
    model_step();
  endtask

  function automatic logic [DW-1:0] rep(input logic [WIDTH-1:0] v);
    return {v, v, v};
  endfunction

  int cnt_tbl [5] = '{1, 1, 2, 3, 2};
  logic       iv_tbl [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; ce = 1'b0; clr = 1'b0; in_valid = 1'b0; din = '0; tap_sel = 3'd2;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("rst.dout",  64'(dout),      64'h0);
    check("rst.valid", 64'(out_valid), 64'h0);
    check("rst.count", 64'(count),     64'h0);
    @(negedge clk);
    reset = 1'b1;

    // Test 1: preload, then an async reset mid-cycle clears at once.
    for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b1, rep(WIDTH'(i + 8'h40)), 3'd2, "preload");
    @(negedge clk);
    ce = 1'b0; tap_sel = 3'd2;
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    check("async.dout",  64'(dout),      64'h0);
    check("async.valid", 64'(out_valid), 64'h0);
    check("async.count", 64'(count),     64'h0);
    din = rep(18'h2abcd); in_valid = 1'b1; tap_sel = 3'd0;
    #1;
    check("async.bypass", 64'(dout), 64'(rep(18'h2abcd)));
    @(negedge clk);
    reset = 1'b1;

    // Test 2: tap 2 latency plus a bypass cycle.
    for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b0, 1'b1, rep(WIDTH'(i)), 3'd2, "lat");
    cycle(1'b1, 1'b0, 1'b0, rep(18'h00006), 3'd0, "bypass");
    cycle(1'b1, 1'b0, 1'b0, '0, 3'd2, "lat_tail");

    // Test 3: stall for 3 edges while din changes, then resume.
    for (int i = 0; i < 3; i++)
      cycle(1'b0, 1'b0, 1'b1, rep(WIDTH'($urandom_range(0, 18'h3ffff))), 3'd3, "stall");
    cycle(1'b1, 1'b0, 1'b1, rep(18'h00077), 3'd3, "resume");
    cycle(1'b1, 1'b0, 1'b1, rep(18'h00078), 3'd1, "resume");

    // Test 4: clr and ce on the same edge; clr wins.
    cycle(1'b1, 1'b1, 1'b1, rep(18'h1ffff), 3'd1, "clr_ce");
    for (int k = 0; k <= DEPTH; k++) cycle(1'b0, 1'b0, 1'b0, '0, TSW'(k), "after_clr");

    // Test 5: count sequence on the DEPTH=4 pipe.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, iv_tbl[i], rep(WIDTH'(i + 3)), 3'd4, "cnt_seq");
      #1;
      check("cnt_tbl", 64'(count), 64'(cnt_tbl[i]));
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b1, rep(WIDTH'(i)), 3'd4, "cnt_full");

    // Test 6: distinct lanes, and tap 7 clamps to tap 4.
    cycle(1'b1, 1'b0, 1'b1, {18'h15555, 18'h00000, 18'h3ffff}, 3'd7, "lanes");
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, '0, 3'd7, "lanes_shift");
    @(negedge clk);
    ce = 1'b0; tap_sel = 3'd7;
    #1;
    check("lane0", 64'(dout[0*WIDTH +: WIDTH]), 64'h3ffff);
    check("lane1", 64'(dout[1*WIDTH +: WIDTH]), 64'h00000);
    check("lane2", 64'(dout[2*WIDTH +: WIDTH]), 64'h15555);
    check("clamp_valid", 64'(out_valid), 64'h1);

    // Random mix of ce, clr, valid and taps.
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
            {WIDTH'($urandom_range(0, 18'h3ffff)), WIDTH'($urandom_range(0, 18'h3ffff)),
             WIDTH'($urandom_range(0, 18'h3ffff))},
            TSW'($urandom_range(0, 7)), "rand");

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
